pipe_msg_serializer: RTL and testbench

- Downstream consumer of the method-to-pipe packer.
- Accepts one wide packed message per enq call, buffers it in a small message FIFO, and emits it as a stream of 32-bit beats with a last flag toward the portal/transport.
- The beat count is taken from the message's embedded length field.
- Lets the packer run at one message per cycle while the narrow link drains.

---
 rtl/pipe_msg_serializer_pkg.sv | 28 ++
 rtl/pipe_msg_serializer_msg_fifo.sv | 75 +++++++
 rtl/pipe_msg_serializer.sv | 164 ++++++++++++++++
 tb/tb_pipe_msg_serializer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_msg_serializer_pkg.sv
// Shared definitions for the packed-message serializer: header field
// positions, the header view of a message and the serializer FSM states.
package pipe_msg_serializer_pkg;

    localparam int BEAT_W  = 32;   // width of one output beat
    localparam int MID_LSB = 0;    // method id sits in the lowest bits
    localparam int MID_W   = 16;
    localparam int LEN_OFS = 16;   // length field starts this many bits below the message MSB
    localparam int LEN_W   = 16;

    // Header fields carried inside every packed message.
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [MID_W-1:0] method_id;
    } msg_hdr_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Limit a requested beat count to what the message can actually hold.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw,
                                                   input logic [LEN_W-1:0] max_len);
        return (raw > max_len) ? max_len : raw;
    endfunction

endpackage

// File: rtl/pipe_msg_serializer_msg_fifo.sv
// Small message FIFO: MSG_WIDTH x FIFO_DEPTH, registered occupancy count,
// head entry always visible on rd_data. Writes when full and reads when
// empty are ignored.
module msg_fifo
    import pipe_msg_serializer_pkg::*;
#(
    parameter int MSG_WIDTH  = 192,
    parameter int FIFO_DEPTH = 2,
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [MSG_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    output logic [MSG_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    logic [MSG_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 do_wr;
    logic                 do_rd;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Pointer and occupancy updates; pointers wrap naturally (depth is a power of 2).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/pipe_msg_serializer.sv
// Serializes wide packed messages into 32-bit beats with a last flag.
// Messages are buffered in a small FIFO so the packer can push one per
// cycle while the narrow link drains; the beat count comes from the
// length field embedded in each message.
module pipe_msg_serializer
    import pipe_msg_serializer_pkg::*;
#(
    parameter int MSG_WIDTH  = 192,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 enq__ENA,
    input  logic [MSG_WIDTH-1:0] enq_v,
    output logic                 enq__RDY,
    output logic                 out__ENA,
    output logic [31:0]          out_data,
    output logic                 out_last,
    input  logic                 out__RDY,
    output logic [31:0]          msg_count,
    output logic                 err_drop,
    output logic                 err_clamp,
    output logic                 err_ovf
);

    localparam int               MAX_BEATS = MSG_WIDTH / BEAT_W;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BEATS);
    localparam int               LEN_MSB   = MSG_WIDTH - LEN_OFS - 1;
    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;

    ser_state_t           state_q, state_d;
    logic [MSG_WIDTH-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [31:0]          msg_count_q, msg_count_d;
    logic                 err_drop_q, err_drop_d;
    logic                 err_clamp_q, err_clamp_d;
    logic                 err_ovf_q, err_ovf_d;

    logic                 fifo_wr;
    logic                 fifo_pop;
    logic [MSG_WIDTH-1:0] fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LEN_W-1:0]     head_len;
    logic                 is_last;
    logic                 take;

    // Ready depends only on the registered occupancy, never on out__RDY,
    // so a full FIFO refuses a write even when a pop happens that cycle.
    assign enq__RDY = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_wr  = enq__ENA && enq__RDY;
    assign head_len = fifo_head[LEN_MSB -: LEN_W];
    assign is_last  = (beat_cnt_q == (len_q - LEN_W'(1)));

    msg_fifo #(
        .MSG_WIDTH  (MSG_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (nRST),
        .wr_en   (fifo_wr),
        .wr_data (enq_v),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state logic: beat stepping, message loading (with drop/clamp) and sticky errors.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        msg_count_d = msg_count_q;
        err_drop_d  = err_drop_q;
        err_clamp_d = err_clamp_q;
        err_ovf_d   = err_ovf_q | (enq__ENA & fifo_full);
        take        = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                take = !fifo_empty;
            end
            SEND: begin
                if (out__RDY) begin
                    if (!is_last) begin
                        shift_d    = shift_q >> BEAT_W;
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end else begin
                        msg_count_d = msg_count_q + 32'd1;
                        // Chain straight into the next message to avoid a bubble.
                        if (!fifo_empty) begin
                            take = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            fifo_pop = 1'b1;
            if (head_len == '0) begin
                err_drop_d = 1'b1;
                state_d    = IDLE;
            end else begin
                state_d    = SEND;
                shift_d    = fifo_head;
                beat_cnt_d = '0;
                len_d      = clamp_len(head_len, MAX_LEN);
                if (head_len > MAX_LEN) begin
                    err_clamp_d = 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and sticky error flags; reset also clears the beat output.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            shift_q     <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            msg_count_q <= '0;
            err_drop_q  <= 1'b0;
            err_clamp_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            msg_count_q <= msg_count_d;
            err_drop_q  <= err_drop_d;
            err_clamp_q <= err_clamp_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign out__ENA  = (state_q == SEND);
    assign out_data  = shift_q[BEAT_W-1:0];
    assign out_last  = out__ENA && is_last;
    assign msg_count = msg_count_q;
    assign err_drop  = err_drop_q;
    assign err_clamp = err_clamp_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_pipe_msg_serializer.sv
// Scoreboard bench for pipe_msg_serializer: accepted messages are expanded
// into expected beats by a message-level model; a monitor pops and compares.
module tb_pipe_msg_serializer;
    import pipe_msg_serializer_pkg::*;

    localparam int MW = 192;
    localparam int NB = MW / 32;

    logic          CLK = 1'b0;
    logic          nRST = 1'b1;
    logic          enq__ENA = 1'b0;
    logic [MW-1:0] enq_v = '0;
    logic          enq__RDY;
    logic          out__ENA;
    logic [31:0]   out_data;
    logic          out_last;
    logic          out__RDY = 1'b0;
    logic [31:0]   msg_count;
    logic          err_drop;
    logic          err_clamp;
    logic          err_ovf;

    pipe_msg_serializer #(.MSG_WIDTH(MW), .FIFO_DEPTH(2)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .enq__ENA  (enq__ENA),
        .enq_v     (enq_v),
        .enq__RDY  (enq__RDY),
        .out__ENA  (out__ENA),
        .out_data  (out_data),
        .out_last  (out_last),
        .out__RDY  (out__RDY),
        .msg_count (msg_count),
        .err_drop  (err_drop),
        .err_clamp (err_clamp),
        .err_ovf   (err_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    acc_cnt = 0;
    int    exp_msgs = 0;
    logic  exp_drop = 1'b0;
    logic  exp_clamp = 1'b0;
    logic  exp_ovf = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [MW-1:0] mk_msg(input logic [15:0] mid, input logic [15:0] len);
        logic [MW-1:0] m;
        msg_hdr_t      h;
        for (int i = 0; i < NB; i++) m[32*i +: 32] = $urandom;
        h.method_id = mid;
        h.len       = len;
        m[MID_LSB +: MID_W]        = h.method_id;
        m[MW-LEN_OFS-1 -: LEN_W]   = h.len;
        return m;
    endfunction

    // Message-level reference: what an accepted message must turn into.
    function automatic void model_accept(input logic [MW-1:0] m);
        int    l;
        int    n;
        beat_t b;
        l = int'(m[MW-LEN_OFS-1 -: LEN_W]);
        if (l == 0) begin
            exp_drop = 1'b1;
            return;
        end
        if (l > NB) exp_clamp = 1'b1;
        n = (l > NB) ? NB : l;
        for (int i = 0; i < n; i++) begin
            b.data = m[32*i +: 32];
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
        exp_msgs++;
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        exp_msgs  = 0;
        exp_drop  = 1'b0;
        exp_clamp = 1'b0;
        exp_ovf   = 1'b0;
    endfunction

    // Enqueue side: record what the DUT accepts (or refuses) this cycle.
    always @(negedge CLK) begin
        if (!nRST) begin
            if (enq__ENA && enq__RDY) begin
                model_accept(enq_v);
                acc_cnt++;
            end
            if (enq__ENA && !enq__RDY) exp_ovf = 1'b1;
        end
    end

    // Output side: compare every transferred beat and check stall stability.
    always @(negedge CLK) begin
        beat_t b;
        if (!nRST) begin
            if (prev_stall) begin
                check("hold_ena", {31'd0, out__ENA}, 32'd1);
                check("hold_data", out_data, prev_data);
                check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out__ENA && out__RDY) begin
                beats_seen++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("extra_beat", out_data, 32'hDEAD_0000);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_last", {31'd0, out_last}, {31'd0, b.last});
                end
            end
            prev_stall = out__ENA && !out__RDY;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_reset();
        nRST     = 1'b1;
        enq__ENA = 1'b0;
        out__RDY = 1'b0;
        flush_model();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
    endtask

    task automatic enq1(input logic [MW-1:0] m);
        enq_v    = m;
        enq__ENA = 1'b1;
        @(posedge CLK);
        #1;
        enq__ENA = 1'b0;
    endtask

    task automatic drain();
        int idle = 0;
        int k    = 0;
        out__RDY = 1'b1;
        enq__ENA = 1'b0;
        while (idle < 4 && k < 800) begin
            @(negedge CLK);
            k++;
            if (exp_q.size() == 0 && !out__ENA) idle++;
            else idle = 0;
        end
        check("drain_done", {31'd0, idle >= 4}, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_msg_count"}, msg_count, 32'(exp_msgs));
        check({tag, "_err_drop"}, {31'd0, err_drop}, {31'd0, exp_drop});
        check({tag, "_err_clamp"}, {31'd0, err_clamp}, {31'd0, exp_clamp});
        check({tag, "_err_ovf"}, {31'd0, err_ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int b0;
        int a0;
        int k;

        // Reset state
        do_reset();
        @(negedge CLK);
        check("rst_enq_rdy", {31'd0, enq__RDY}, 32'd1);
        check("rst_out_ena", {31'd0, out__ENA}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check_flags("rst");
        @(posedge CLK);
        #1;

        // Single message, len 5, method id 3: latency and header in first beat
        out__RDY = 1'b1;
        b0 = beats_seen;
        t0 = cyc;
        enq1(mk_msg(16'd3, 16'd5));
        k = 0;
        while (k < 20) begin
            @(negedge CLK);
            if (out__ENA) break;
            k++;
        end
        check("latency", 32'(cyc - t0), 32'd2);
        check("w0_method_id", {16'd0, out_data[15:0]}, 32'h3);
        @(posedge CLK);
        #1;
        drain();
        check("single_beats", 32'(beats_seen - b0), 32'd5);
        check_flags("single");

        // Backpressure 1,0,0 pattern
        do_reset();
        b0 = beats_seen;
        out__RDY = 1'b1;
        enq1(mk_msg(16'd3, 16'd5));
        for (int i = 0; i < 30; i++) begin
            out__RDY = (i % 3 == 2);
            @(posedge CLK);
            #1;
        end
        drain();
        check("bp_beats", 32'(beats_seen - b0), 32'd5);
        check_flags("bp");

        // Back-to-back three messages
        do_reset();
        out__RDY = 1'b1;
        b0 = beats_seen;
        enq_v = mk_msg(16'd10, 16'd5); enq__ENA = 1'b1;
        @(posedge CLK); #1;
        enq_v = mk_msg(16'd11, 16'd5);
        @(posedge CLK); #1;
        enq_v = mk_msg(16'd12, 16'd5);
        @(posedge CLK); #1;
        enq__ENA = 1'b0;
        @(negedge CLK);
        check("b2b_rdy_drop", {31'd0, enq__RDY}, 32'd0);
        @(posedge CLK); #1;
        drain();
        check("b2b_beats", 32'(beats_seen - b0), 32'd15);
        if (beats_seen - b0 >= 15)
            check("b2b_contiguous", 32'(beat_cyc[b0+14] - beat_cyc[b0]), 32'd14);
        check_flags("b2b");

        // len 0 followed by len 2
        do_reset();
        out__RDY = 1'b1;
        b0 = beats_seen;
        enq1(mk_msg(16'd20, 16'd0));
        enq1(mk_msg(16'd21, 16'd2));
        drain();
        check("drop_beats", 32'(beats_seen - b0), 32'd2);
        check("drop_flag", {31'd0, err_drop}, 32'd1);
        check_flags("drop");

        // len 9 clamped to MAX_BEATS
        do_reset();
        out__RDY = 1'b1;
        b0 = beats_seen;
        enq1(mk_msg(16'd30, 16'd9));
        drain();
        check("clamp_beats", 32'(beats_seen - b0), 32'(NB));
        check("clamp_flag", {31'd0, err_clamp}, 32'd1);
        check_flags("clamp");

        // Overflow while full
        do_reset();
        out__RDY = 1'b0;
        b0 = beats_seen;
        a0 = acc_cnt;
        enq__ENA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_v = mk_msg(16'(40 + i), 16'd2);
            @(posedge CLK);
            #1;
        end
        enq__ENA = 1'b0;
        check("ovf_accepted", 32'(acc_cnt - a0), 32'd3);
        drain();
        check("ovf_beats", 32'(beats_seen - b0), 32'd6);
        check("ovf_flag", {31'd0, err_ovf}, 32'd1);
        check_flags("ovf");

        // Reset during beat 2 of 5
        do_reset();
        out__RDY = 1'b1;
        b0 = beats_seen;
        enq1(mk_msg(16'd50, 16'd5));
        k = 0;
        while (beats_seen < b0 + 1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("rst_mid_start", 32'(beats_seen - b0), 32'd1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        flush_model();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(negedge CLK);
        check("rst_mid_ena", {31'd0, out__ENA}, 32'd0);
        check("rst_mid_count", msg_count, 32'd0);
        check("rst_mid_rdy", {31'd0, enq__RDY}, 32'd1);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (out__ENA || out_last) k++;
        end
        check("rst_mid_quiet", 32'(k), 32'd0);
        @(posedge CLK);
        #1;

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            out__RDY = ($urandom_range(0, 9) < 7);
            enq__ENA = ($urandom_range(0, 2) == 0);
            enq_v    = mk_msg(16'($urandom), 16'($urandom_range(0, 9)));
            @(posedge CLK);
            #1;
        end
        drain();
        check_flags("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
